// File: rtl/uart_debug_ctrl.sv
// UART debug controller: run/halt/step control of the CPU clock enable and a
// framed memory dump (A5, words MSB-first, XOR checksum) through a small FWFT byte FIFO.
module uart_debug_ctrl #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 64,
  parameter int NW_BIT = 6,
  parameter int FIFO_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done_tick,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done_tick,
  output logic [NW_BIT-1:0] dbg_addr,
  input  logic [WORD_W-1:0] dbg_data,
  output logic              clk_enable,
  output logic              busy
);

  localparam int NBYTES = WORD_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int DEPTH  = 1 << FIFO_W;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_SEND, S_CSUM} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_run, r_step;
  logic                r_inflight, r_stale;
  logic [NW_BIT-1:0]   r_addr;
  logic [WORD_W-1:0]   r_shift;
  logic [IDX_W-1:0]    r_idx;
  logic [7:0]          r_csum;
  logic [7:0]          r_mem [DEPTH];
  logic [FIFO_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FIFO_W:0]     r_count;

  logic                w_full, w_empty, w_push, w_pop;
  logic [7:0]          w_push_data;
  logic                w_cmd_r, w_cmd_h, w_cmd_s, w_cmd_d, w_d_ok;
  logic                w_last_byte, w_last_word;

  assign w_cmd_r = rx_done_tick && (rx_data == 8'h72);
  assign w_cmd_h = rx_done_tick && (rx_data == 8'h68);
  assign w_cmd_s = rx_done_tick && (rx_data == 8'h73);
  assign w_cmd_d = rx_done_tick && (rx_data == 8'h64);

  assign w_full      = (r_count == (FIFO_W+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  // r_stale holds off new transfers until a byte started before reset has finished
  assign w_pop       = !w_empty && !r_inflight && !r_stale;
  assign w_last_byte = (r_idx == IDX_W'(NBYTES - 1));
  assign w_last_word = (r_addr == NW_BIT'(NWORDS - 1));

  assign busy       = (r_state != S_IDLE) || !w_empty || r_inflight;
  assign clk_enable = r_run | r_step;
  assign w_d_ok     = w_cmd_d && !clk_enable && !busy;
  assign tx_start   = w_pop;
  assign tx_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign dbg_addr   = r_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = 8'h00;
    case (r_state)
      S_IDLE: if (w_d_ok) w_state_nxt = S_HDR;
      S_HDR: if (!w_full) begin
        w_push      = 1'b1;
        w_push_data = 8'hA5;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: w_state_nxt = S_SEND;
      S_SEND: if (!w_full) begin
        w_push      = 1'b1;
        w_push_data = r_shift[WORD_W-1 -: 8];
        if (w_last_byte) w_state_nxt = w_last_word ? S_CSUM : S_LOAD;
      end
      S_CSUM: if (!w_full) begin
        w_push      = 1'b1;
        w_push_data = r_csum;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run  <= 1'b0;
      r_step <= 1'b0;
    end else begin
      r_step <= w_cmd_s && !clk_enable && !busy;
      if (w_cmd_h)               r_run <= 1'b0;
      else if (w_cmd_r && !busy) r_run <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_csum <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: if (w_d_ok) r_csum <= 8'h00;
        S_HDR:  if (!w_full) r_addr <= '0;
        S_SEND: if (!w_full) begin
          r_csum <= r_csum ^ r_shift[WORD_W-1 -: 8];
          if (w_last_byte && !w_last_word) r_addr <= r_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      r_shift <= dbg_data;
      r_idx   <= '0;
    end else if ((r_state == S_SEND) && !w_full) begin
      r_shift <= r_shift << 8;
      r_idx   <= r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_stale    <= (r_inflight || r_stale || w_pop) && !tx_done_tick;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_pop)             r_inflight <= 1'b1;
      else if (tx_done_tick) r_inflight <= 1'b0;
      if (tx_done_tick) r_stale <= 1'b0;
    end
  end

endmodule
